// File: rtl/calc_mem_responder_pkg.sv
// Shared calculator constants, memory FSM state type and address range helper.
package calc_mem_responder_pkg;

    localparam int DATA_W          = 32;
    localparam int MEM_WORD_SIZE   = 64;
    localparam int ADDR_W          = 9;
    localparam int MEM_DEPTH       = 512;
    localparam int MEM_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_RESP
    } mem_state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/calc_mem_array.sv
// Word storage with per-half write enables and a registered, resettable read port.
// Latency: read data valid the cycle after rd_en_i; no backpressure (always accepts).
module calc_mem_array #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int DEPTH         = 512,
    parameter int IDX_W         = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [1:0]               half_en_i,
    input  logic [IDX_W-1:0]         wr_addr_i,
    input  logic [MEM_WORD_SIZE-1:0] wdata_i,
    input  logic                     rd_en_i,
    input  logic                     rd_zero_i,
    input  logic [IDX_W-1:0]         rd_addr_i,
    output logic [MEM_WORD_SIZE-1:0] rdata_o
);

    logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];
    logic [MEM_WORD_SIZE-1:0] rdata_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (half_en_i[0]) mem_q[wr_addr_i][DATA_W-1:0] <= wdata_i[DATA_W-1:0];
            if (half_en_i[1]) mem_q[wr_addr_i][MEM_WORD_SIZE-1:DATA_W] <= wdata_i[MEM_WORD_SIZE-1:DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[rd_addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/calc_mem_responder.sv
// Memory responder: ready/ack handshake, ack WAIT_CYCLES+1 after accept, ready low until ack done.
// Optional CALC_MEM_RANGE_CHECK_EN drives err_o on out-of-range accesses.
module calc_mem_responder #(
    parameter int DATA_W        = calc_mem_responder_pkg::DATA_W,
    parameter int MEM_WORD_SIZE = calc_mem_responder_pkg::MEM_WORD_SIZE,
    parameter int ADDR_W        = calc_mem_responder_pkg::ADDR_W,
    parameter int DEPTH         = calc_mem_responder_pkg::MEM_DEPTH,
    parameter int WAIT_CYCLES   = calc_mem_responder_pkg::MEM_WAIT_CYCLES
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [1:0]               half_en_i,
    input  logic [MEM_WORD_SIZE-1:0] wdata_i,
    output logic                     ready_o,
    output logic                     ack_o,
    output logic [MEM_WORD_SIZE-1:0] rdata_o,
    output logic                     err_o
);

    import calc_mem_responder_pkg::*;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                     we_q;
    logic [IDX_W-1:0]         addr_q;
    logic [1:0]               half_en_q;
    logic [MEM_WORD_SIZE-1:0] wdata_q;
    logic                     in_range_q;

    logic                     in_range_i;
    logic                     accept;
    logic                     acc_we;
    logic                     acc_in_range;
    logic [IDX_W-1:0]         acc_addr;
    logic                     wr_en;
    logic                     rd_en;

    assign in_range_i = addr_in_range(32'(addr_i), DEPTH);
    assign accept     = req_i && (state_q == M_IDLE) && !rst_i;

    // With zero wait cycles the read is issued on the accept edge, so the
    // access fields come straight from the ports instead of the latches.
    assign acc_we       = (state_q == M_IDLE) ? we_i : we_q;
    assign acc_addr     = (state_q == M_IDLE) ? addr_i[IDX_W-1:0] : addr_q;
    assign acc_in_range = (state_q == M_IDLE) ? in_range_i : in_range_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            half_en_q  <= '0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
        end else if (accept) begin
            we_q       <= we_i;
            addr_q     <= addr_i[IDX_W-1:0];
            half_en_q  <= half_en_i;
            wdata_q    <= wdata_i;
            in_range_q <= in_range_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            M_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = M_RESP;
                    end else begin
                        state_d = M_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            M_WAIT: begin
                if (cnt_q == 4'd0) state_d = M_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            M_RESP:  state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == M_IDLE) && !rst_i;
        ack_o   = (state_q == M_RESP) && !rst_i;
        wr_en   = ack_o && we_q && in_range_q;
        rd_en   = (state_d == M_RESP) && (state_q != M_RESP) && !rst_i && !acc_we;
`ifdef CALC_MEM_RANGE_CHECK_EN
        err_o   = ack_o && !in_range_q;
`else
        err_o   = 1'b0;
`endif
    end

    calc_mem_array #(
        .DATA_W        (DATA_W),
        .MEM_WORD_SIZE (MEM_WORD_SIZE),
        .DEPTH         (DEPTH),
        .IDX_W         (IDX_W)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .half_en_i (half_en_q),
        .wr_addr_i (addr_q),
        .wdata_i   (wdata_q),
        .rd_en_i   (rd_en),
        .rd_zero_i (!acc_in_range),
        .rd_addr_i (acc_addr),
        .rdata_o   (rdata_o)
    );

endmodule

// File: tb/tb_calc_mem_responder.sv
// Directed bench with a scoreboard for calc_mem_responder (three parameterisations).
module tb_calc_mem_responder;

    localparam int DEPTH_A = 256;
`ifdef CALC_MEM_RANGE_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WAIT_CYCLES=1, DEPTH=256
    logic        req_a = 0, we_a = 0;
    logic [8:0]  addr_a = '0;
    logic [1:0]  he_a = '0;
    logic [63:0] wd_a = '0;
    logic        ready_a, ack_a, err_a;
    logic [63:0] rdata_a;

    // Instances B (WAIT_CYCLES=0) and C (WAIT_CYCLES=3) share stimulus
    logic        req_l = 0, we_l = 0;
    logic [8:0]  addr_l = '0;
    logic [1:0]  he_l = '0;
    logic [63:0] wd_l = '0;
    logic        ready_b, ack_b, err_b, ready_c, ack_c, err_c;
    logic [63:0] rdata_b, rdata_c;

    calc_mem_responder #(.DEPTH(DEPTH_A), .WAIT_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .half_en_i(he_a), .wdata_i(wd_a), .ready_o(ready_a), .ack_o(ack_a),
        .rdata_o(rdata_a), .err_o(err_a));

    calc_mem_responder #(.WAIT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_l), .we_i(we_l), .addr_i(addr_l),
        .half_en_i(he_l), .wdata_i(wd_l), .ready_o(ready_b), .ack_o(ack_b),
        .rdata_o(rdata_b), .err_o(err_b));

    calc_mem_responder #(.WAIT_CYCLES(3)) dut_c (
        .clk_i(clk), .rst_i(rst), .req_i(req_l), .we_i(we_l), .addr_i(addr_l),
        .half_en_i(he_l), .wdata_i(wd_l), .ready_o(ready_c), .ack_o(ack_c),
        .rdata_o(rdata_c), .err_o(err_c));

    typedef struct {
        logic        we;
        logic        err;
        logic [63:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [int];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: computes the expected response at accept time.
    task automatic push_exp(input logic w, input logic [8:0] a, input logic [1:0] h,
                            input logic [63:0] d);
        exp_t        e;
        logic        oor;
        logic [63:0] old;
        oor     = (int'(a) >= DEPTH_A);
        e.we    = w;
        e.err   = oor ? ERR_EXP : 1'b0;
        e.rdata = '0;
        if (w) begin
            if (!oor) begin
                old = model.exists(int'(a)) ? model[int'(a)] : 64'bx;
                if (h[0]) old[31:0]  = d[31:0];
                if (h[1]) old[63:32] = d[63:32];
                model[int'(a)] = old;
            end
        end else begin
            e.rdata = oor ? 64'd0 : (model.exists(int'(a)) ? model[int'(a)] : 64'bx);
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_ack"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_err"}, 64'(err_a), 64'(e.err));
            if (!e.we) chk({tag, "_rdata"}, rdata_a, e.rdata);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the ack cycle.
    task automatic access(input string tag, input logic w, input logic [8:0] a,
                          input logic [1:0] h, input logic [63:0] d);
        int cyc;
        int lat;
        req_a = 1'b1; we_a = w; addr_a = a; he_a = h; wd_a = d;
        cyc = 0;
        while (!ready_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        push_exp(w, a, h, d);
        @(negedge clk);
        req_a = 1'b0;
        lat = 1;
        while (!ack_a && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_ack_seen"}, 64'(ack_a), 64'd1);
        if (ack_a) begin
            chk({tag, "_latency"}, 64'(lat), 64'd2);
            chk({tag, "_ready_in_ack"}, 64'(ready_a), 64'd0);
            pop_check(tag);
        end
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(ready_a), 64'd1);
        chk({tag, "_no_ack_after"}, 64'(ack_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accepts;
        int acks;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready_a), 64'd0);
        chk("rst_ack", 64'(ack_a), 64'd0);
        chk("rst_rdata", rdata_a, 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_a), 64'd1);

        // Full write, partial write, no-op write, each followed by a read
        access("wr_full", 1'b1, 9'd5, 2'b11, 64'h1122334455667788);
        access("rd_full", 1'b0, 9'd5, 2'b00, 64'd0);
        access("wr_lo", 1'b1, 9'd5, 2'b01, 64'hAAAAAAAABBBBBBBB);
        access("rd_lo", 1'b0, 9'd5, 2'b11, 64'd0);
        access("wr_none", 1'b1, 9'd5, 2'b00, 64'hDEADBEEFDEADBEEF);
        access("rd_none", 1'b0, 9'd5, 2'b00, 64'd0);
        chk("model_merge", model[5], 64'h11223344BBBBBBBB);

        // Reset while in M_WAIT abandons the write
        access("wr_zero7", 1'b1, 9'd7, 2'b11, 64'd0);
        req_a = 1'b1; we_a = 1'b1; addr_a = 9'd7; he_a = 2'b11; wd_a = 64'hFF;
        chk("rst_mid_ready", 64'(ready_a), 64'd1);
        @(negedge clk);
        req_a = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_ack0", 64'(ack_a), 64'd0);
        @(negedge clk);
        chk("rst_mid_ack1", 64'(ack_a), 64'd0);
        chk("rst_mid_ready_low", 64'(ready_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_ready_back", 64'(ready_a), 64'd1);
        @(negedge clk);
        access("rd_after_rst", 1'b0, 9'd7, 2'b11, 64'd0);

        // Held request for 10 cycles: one ack per accept
        accepts = 0;
        acks = 0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 9'd5; he_a = 2'b00;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) req_a = 1'b0;
            if (ack_a) begin
                acks++;
                chk("held_ready_in_ack", 64'(ready_a), 64'd0);
                pop_check("held");
            end
            if (req_a && ready_a) begin
                accepts++;
                push_exp(1'b0, 9'd5, 2'b00, 64'd0);
            end
            @(negedge clk);
        end
        chk("held_accepts", 64'(accepts), 64'd4);
        chk("held_acks", 64'(acks), 64'd4);
        chk("held_sb_drained", 64'(sb.size()), 64'd0);

        // Boundaries and out-of-range (DEPTH=256)
        access("wr_top", 1'b1, 9'd255, 2'b11, 64'hA5A5A5A5_00000255);
        access("wr_bot", 1'b1, 9'd0, 2'b11, 64'h5A5A5A5A_00000000);
        access("rd_top", 1'b0, 9'd255, 2'b11, 64'd0);
        access("wr_oor", 1'b1, 9'd300, 2'b11, 64'h0123456789ABCDEF);
        access("rd_oor", 1'b0, 9'd300, 2'b11, 64'd0);
        access("rd_bot", 1'b0, 9'd0, 2'b11, 64'd0);
        access("rd_top2", 1'b0, 9'd255, 2'b11, 64'd0);

        // Latency: B (WAIT_CYCLES=0) and C (WAIT_CYCLES=3) accept on the same edge
        req_l = 1'b1; we_l = 1'b1; addr_l = 9'd1; he_l = 2'b11; wd_l = 64'hCAFEF00D12345678;
        chk("lat_b_ready_T", 64'(ready_b), 64'd1);
        chk("lat_c_ready_T", 64'(ready_c), 64'd1);
        @(negedge clk);
        req_l = 1'b0;
        chk("lat_b_ack_T1", 64'(ack_b), 64'd1);
        chk("lat_b_ready_T1", 64'(ready_b), 64'd0);
        chk("lat_c_ack_T1", 64'(ack_c), 64'd0);
        chk("lat_c_ready_T1", 64'(ready_c), 64'd0);
        @(negedge clk);
        chk("lat_b_ack_T2", 64'(ack_b), 64'd0);
        chk("lat_b_ready_T2", 64'(ready_b), 64'd1);
        chk("lat_c_ack_T2", 64'(ack_c), 64'd0);
        @(negedge clk);
        chk("lat_c_ack_T3", 64'(ack_c), 64'd0);
        chk("lat_c_ready_T3", 64'(ready_c), 64'd0);
        @(negedge clk);
        chk("lat_c_ack_T4", 64'(ack_c), 64'd1);
        chk("lat_c_ready_T4", 64'(ready_c), 64'd0);
        chk("lat_c_err_T4", 64'(err_c), 64'd0);
        @(negedge clk);
        chk("lat_c_ack_T5", 64'(ack_c), 64'd0);
        chk("lat_c_ready_T5", 64'(ready_c), 64'd1);

        req_l = 1'b1; we_l = 1'b0;
        @(negedge clk);
        req_l = 1'b0;
        chk("rd_b_ack", 64'(ack_b), 64'd1);
        chk("rd_b_rdata", rdata_b, 64'hCAFEF00D12345678);
        chk("rd_b_err", 64'(err_b), 64'd0);
        repeat (3) @(negedge clk);
        chk("rd_c_ack", 64'(ack_c), 64'd1);
        chk("rd_c_rdata", rdata_c, 64'hCAFEF00D12345678);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_mem_responder.md
# calc_mem_responder

Memory-side responder for the calculator datapath. It answers the read and write requests issued by the calculator controller (operand reads, result writes) against a `DEPTH` x 64-bit word array. Every access uses a ready/ack handshake with a configurable number of wait cycles, so the controller's wait and write-wait states are exercised against realistic latency. The block serves as the SRAM model in simulation and as the memory front-end in synthesis.

## Interface
Parameters:
- `DATA_W`, 32: half-word width; a memory word is two halves.
- `MEM_WORD_SIZE`, 64: memory word width.
- `ADDR_W`, 9: address width.
- `DEPTH`, 512: number of implemented words, 1..2^`ADDR_W`.
- `WAIT_CYCLES`, 1: extra cycles between accept and ack, 0..15.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  1  request valid.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  `ADDR_W`  word address.
- `half_en_i`  in  2  write enables; bit0 = [31:0], bit1 = [63:32].
- `wdata_i`  in  `MEM_WORD_SIZE`  write data.
- `ready_o`  out  1  responder can accept a request this cycle.
- `ack_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  `MEM_WORD_SIZE`  read data; valid with `ack_o` on reads, held until the next read ack.
- `err_o`  out  1  access error, valid with `ack_o`.

## Operation
- FSM states are `M_IDLE`, `M_WAIT` and `M_RESP`. `ready_o` = (state == `M_IDLE`) && !`rst_i`.
- **Accept:** `req_i && ready_o` latches `we_i`, `addr_i`, `half_en_i` and `wdata_i`.
  - If `WAIT_CYCLES` == 0, go to `M_RESP`.
  - Otherwise, load the wait counter with `WAIT_CYCLES`-1 and go to `M_WAIT`.
- **M_WAIT:** decrement the counter; go to `M_RESP` when it reaches 0.
- **M_RESP:** perform the access, pulse `ack_o`, then return to `M_IDLE`.
  - Write: update each half whose `half_en` bit is set. `half_en` = 00 is a legal no-op that still acks.
  - Read: `rdata_o` <= array[addr]. `half_en` is ignored.
- `req_i` while `ready_o`=0 is ignored. The initiator holds its request until accepted, and a held request is accepted once.
- The memory array is not reset. Contents are X until written.

## Timing
- Accept at cycle T gives `ack_o` at T+`WAIT_CYCLES`+1. `ready_o` is low from T+1 through the ack cycle and high at T+`WAIT_CYCLES`+2.
- Throughput is one access per `WAIT_CYCLES`+2 cycles.
- Read-after-write: a read accepted after the write's ack returns the new data.
- Reset values: state `M_IDLE`, counter 0, `ack_o` 0, `rdata_o` 0, `err_o` 0. `ready_o` is 0 during reset and 1 on the first cycle after.
- Reset mid-operation abandons the access with no ack and no partial write. Reset has priority in the `M_RESP` cycle.
- Addresses 0 and `DEPTH`-1 are normal. There is no wrap-around.

## Configuration
- With `CALC_MEM_RANGE_CHECK_EN` defined, an access with `addr` >= `DEPTH` still completes with normal latency and `ack_o`, plus:
  - `err_o`=1 for that ack cycle;
  - write suppressed;
  - `rdata_o`=0.
- Without `CALC_MEM_RANGE_CHECK_EN`:
  - out-of-range writes are silently dropped;
  - out-of-range reads return 0;
  - `err_o` is tied to 0.

## Structure
- Shared calculator package:
  - `mem_state_t` enum {`M_IDLE`, `M_WAIT`, `M_RESP`};
  - `MEM_DEPTH` = 512;
  - `MEM_WAIT_CYCLES` default;
  - existing `DATA_W`, `MEM_WORD_SIZE`, `ADDR_W`.
- One natural sub-module: `calc_mem_array`, the storage with a per-half write enable and registered read. The FSM, wait counter and range check stay in the top.

## Test plan
- Write 0x1122334455667788 to addr 5 (`half_en` 11), then read addr 5 → `rdata_o`=0x1122334455667788 and `err_o`=0.
- Then write 0xAAAAAAAABBBBBBBB to addr 5 with `half_en` 01, read addr 5 → 0x11223344BBBBBBBB. A write with `half_en` 00 acks and leaves the data unchanged.
- Latency: with `WAIT_CYCLES`=0, accept at T gives ack at T+1; with `WAIT_CYCLES`=3, ack at T+4. `ready_o` is low T+1..ack and high the following cycle.
- Write 0 to addr 7, then start a write of 0xFF to addr 7 and assert `rst_i` during `M_WAIT` → no ack, `ready_o` returns after reset, and a read of addr 7 returns 0.
- `req_i` held high for 10 cycles with `WAIT_CYCLES`=1 → exactly one ack per accept, and accepts occur only while `ready_o`=1.
- `DEPTH`=256: write addr 300 then read addr 300 → with `CALC_MEM_RANGE_CHECK_EN`, `err_o`=1 on both acks and `rdata_o`=0; without it, `err_o`=0 and `rdata_o`=0. Addr 255 and addr 0 hold distinct values.
